bcd_counter_nd: RTL and testbench

- Parametrised N-digit BCD up/down counter with a built-in tick prescaler and per-digit 7-segment outputs.
- It is the next-generation counter/divider/display chain for the DE2 top level.
- A single instance is clocked directly from CLOCK_50 and drives the HEX displays directly; no separate 1 Hz clock domain is used.
- Adds direction control, parallel BCD load, count enable, and wrap signalling.

---
 rtl/bcd_counter_nd.sv | 114 +++++++++++
 tb/tb_bcd_counter_nd.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_nd.sv
// N-digit BCD up/down counter with tick prescaler, parallel load,
// wrap flag and active-low 7-segment outputs.
module bcd_counter_nd #(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 50_000_000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  tick,
   output logic                  wrap,
   output logic [7*DIGITS-1:0]   seg
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

   logic [PW-1:0]       pre;
   logic [4*DIGITS-1:0] nxt;
   logic [4*DIGITS-1:0] load_san;
   logic                nxt_wrap;
   logic                step;

   assign step = en && (pre == PRE_MAX);

   // Ripple carry/borrow; a carry out of the top digit means wrap.
   always_comb begin
      logic       c;
      logic [3:0] d;
      nxt      = '0;
      nxt_wrap = 1'b0;
      c        = 1'b1;
      d        = '0;
      for (int i = 0; i < DIGITS; i++) begin
         d = bcd[4*i +: 4];
         if (!c) begin
            nxt[4*i +: 4] = d;
         end else if (up) begin
            if (d >= 4'd9) begin
               nxt[4*i +: 4] = 4'd0;
            end else begin
               nxt[4*i +: 4] = d + 4'd1;
               c = 1'b0;
            end
         end else begin
            if (d == 4'd0) begin
               nxt[4*i +: 4] = 4'd9;
            end else begin
               nxt[4*i +: 4] = d - 4'd1;
               c = 1'b0;
            end
         end
      end
      nxt_wrap = c;
   end

   always_comb begin
      load_san = '0;
      for (int i = 0; i < DIGITS; i++) begin
         load_san[4*i +: 4] =
            (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         bcd  <= '0;
         pre  <= '0;
         tick <= 1'b0;
         wrap <= 1'b0;
      end else if (load) begin
         bcd  <= load_san;
         pre  <= '0;
         tick <= 1'b0;
         wrap <= 1'b0;
      end else begin
         tick <= 1'b0;
         wrap <= 1'b0;
         if (step) begin
            pre  <= '0;
            bcd  <= nxt;
            tick <= 1'b1;
            wrap <= nxt_wrap;
         end else if (en) begin
            pre <= pre + PW'(1);
         end
      end
   end

   function automatic logic [6:0] seg7(input logic [3:0] d);
      unique case (d)
         4'd0:    seg7 = 7'b0000001;
         4'd1:    seg7 = 7'b1001111;
         4'd2:    seg7 = 7'b0010010;
         4'd3:    seg7 = 7'b0000110;
         4'd4:    seg7 = 7'b1001100;
         4'd5:    seg7 = 7'b0100100;
         4'd6:    seg7 = 7'b0100000;
         4'd7:    seg7 = 7'b0001111;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0000100;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   for (genvar g = 0; g < DIGITS; g++) begin : g_seg
      assign seg[7*g +: 7] = seg7(bcd[4*g +: 4]);
   end

endmodule

// File: tb/tb_bcd_counter_nd.sv
// Bench for bcd_counter_nd: directed vector table, latency sequence,
// and randomized stimulus against a decimal-arithmetic model.
module tb_bcd_counter_nd;

   localparam int DIGITS   = 2;
   localparam int TICK_DIV = 4;

   logic        clk = 1'b0;
   logic        rst, en, up, load;
   logic [7:0]  load_val;
   logic [7:0]  bcd;
   logic        tick, wrap;
   logic [13:0] seg;

   int vectors = 0;
   int errors  = 0;

   // model state: count as a plain integer 0..99
   int m_val = 0, m_pre = 0;
   bit m_tick = 0, m_wrap = 0;

   bcd_counter_nd #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
      .load_val(load_val), .bcd(bcd), .tick(tick), .wrap(wrap),
      .seg(seg)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       r, e, u, l;
      bit [7:0] lv;
      bit [7:0] x_bcd;
      bit       x_tick, x_wrap;
   } vec_t;

   vec_t tbl[$];

   function automatic bit [6:0] seg_of(input int d);
      case (d)
         0: return 7'b0000001;
         1: return 7'b1001111;
         2: return 7'b0010010;
         3: return 7'b0000110;
         4: return 7'b1001100;
         5: return 7'b0100100;
         6: return 7'b0100000;
         7: return 7'b0001111;
         8: return 7'b0000000;
         9: return 7'b0000100;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic int san(input int d);
      return (d > 9) ? 0 : d;
   endfunction

   task automatic model_edge();
      if (!rst) begin
         m_val = 0; m_pre = 0; m_tick = 0; m_wrap = 0;
      end else if (load) begin
         m_val = san(int'(load_val[7:4])) * 10 + san(int'(load_val[3:0]));
         m_pre = 0; m_tick = 0; m_wrap = 0;
      end else begin
         m_tick = 0; m_wrap = 0;
         if (en) begin
            if (m_pre == TICK_DIV - 1) begin
               m_pre  = 0;
               m_tick = 1;
               if (up) begin
                  m_wrap = (m_val == 99);
                  m_val  = (m_val + 1) % 100;
               end else begin
                  m_wrap = (m_val == 0);
                  m_val  = (m_val + 99) % 100;
               end
            end else begin
               m_pre++;
            end
         end
      end
   endtask

   task automatic cyc(input bit r, e, u, l, input bit [7:0] lv);
      rst = r; en = e; up = u; load = l; load_val = lv;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic check(input string nm, input bit [7:0] xb,
                        input bit xt, input bit xw);
      bit [13:0] xs;
      xs = {seg_of(int'(xb[7:4])), seg_of(int'(xb[3:0]))};
      vectors++;
      if (bcd !== xb || tick !== xt || wrap !== xw || seg !== xs) begin
         errors++;
         $display("FAIL %s: got bcd=%h tick=%b wrap=%b seg=%b, need bcd=%h tick=%b wrap=%b seg=%b",
                  nm, bcd, tick, wrap, seg, xb, xt, xw, xs);
      end
   endtask

   task automatic add(input bit r, e, u, l, input bit [7:0] lv,
                      input bit [7:0] xb, input bit xt, xw, input int n);
      vec_t v;
      v.r = r; v.e = e; v.u = u; v.l = l; v.lv = lv;
      v.x_bcd = xb; v.x_tick = xt; v.x_wrap = xw;
      for (int i = 0; i < n; i++) tbl.push_back(v);
   endtask

   initial begin
      int edges;
      bit got;
      rst = 0; en = 0; up = 1; load = 0; load_val = 0;

      // reset, then first step at the 4th enabled edge
      add(0,0,1,0,8'h00, 8'h00,0,0, 3);
      add(1,1,1,0,8'h00, 8'h00,0,0, 3);
      add(1,1,1,0,8'h00, 8'h01,1,0, 1);
      add(1,1,1,0,8'h00, 8'h01,0,0, 1);
      // up wrap
      add(1,1,1,1,8'h98, 8'h98,0,0, 1);
      add(1,1,1,0,8'h00, 8'h98,0,0, 3);
      add(1,1,1,0,8'h00, 8'h99,1,0, 1);
      add(1,1,1,0,8'h00, 8'h99,0,0, 3);
      add(1,1,1,0,8'h00, 8'h00,1,1, 1);
      add(1,1,1,0,8'h00, 8'h00,0,0, 1);
      // down borrow and wrap
      add(1,1,0,1,8'h10, 8'h10,0,0, 1);
      add(1,1,0,0,8'h00, 8'h10,0,0, 3);
      add(1,1,0,0,8'h00, 8'h09,1,0, 1);
      add(1,1,0,1,8'h00, 8'h00,0,0, 1);
      add(1,1,0,0,8'h00, 8'h00,0,0, 3);
      add(1,1,0,0,8'h00, 8'h99,1,1, 1);
      // load sanitising, load beats step at pre==3
      add(1,1,1,1,8'h4F, 8'h40,0,0, 1);
      add(1,1,1,0,8'h00, 8'h40,0,0, 3);
      add(1,1,1,1,8'h37, 8'h37,0,0, 1);
      add(1,1,1,0,8'h00, 8'h37,0,0, 3);
      add(1,1,1,0,8'h00, 8'h38,1,0, 1);
      // enable hold at pre==2; up toggles while frozen
      add(1,1,1,0,8'h00, 8'h38,0,0, 2);
      add(1,0,0,0,8'h00, 8'h38,0,0, 10);
      add(1,1,1,0,8'h00, 8'h38,0,0, 1);
      add(1,1,1,0,8'h00, 8'h39,1,0, 1);
      // reset beats load and step
      add(1,1,1,0,8'h00, 8'h39,0,0, 3);
      add(0,1,1,1,8'h55, 8'h00,0,0, 1);
      add(1,0,1,0,8'h00, 8'h00,0,0, 1);

      for (int i = 0; i < tbl.size(); i++) begin
         cyc(tbl[i].r, tbl[i].e, tbl[i].u, tbl[i].l, tbl[i].lv);
         check($sformatf("tbl[%0d]", i),
               tbl[i].x_bcd, tbl[i].x_tick, tbl[i].x_wrap);
      end

      // latency after reset, with a gap in enable mid-period
      cyc(0,0,1,0,8'h00);
      edges = 0;
      got   = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         cyc(1, (i != 1), 1, 0, 8'h00);
         if (i != 1) edges++;
         got = tick;
      end
      vectors++;
      if (!got || edges != TICK_DIV || bcd !== 8'h01) begin
         errors++;
         $display("FAIL latency: got tick=%b after %0d enabled edges bcd=%h, need tick after %0d bcd=01",
                  got, edges, bcd, TICK_DIV);
      end

      // randomized run against the model
      for (int i = 0; i < 2000; i++) begin
         bit r, e, u, l;
         bit [7:0] lv;
         r  = ($urandom_range(0, 59) != 0);
         l  = ($urandom_range(0, 24) == 0);
         e  = ($urandom_range(0, 3) != 0);
         u  = ($urandom_range(0, 7) < 5) ? 1'b1 : 1'b0;
         lv = 8'($urandom);
         cyc(r, e, u, l, lv);
         check($sformatf("rnd[%0d]", i),
               8'(((m_val / 10) << 4) | (m_val % 10)), m_tick, m_wrap);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
